// File: rtl/mprj_logic_high_seq.sv
// Staged tie-high driver for the user-project enable nets: raises WIDTH lines GROUP at a time,
// STEP_CYCLES apart, and lowers them in reverse order. Define MPRJ_LOGIC_LO_EN to add the LO port.
module mprj_logic_high_seq #(
    parameter int WIDTH       = 463,
    parameter int GROUP       = 64,
    parameter int STEP_CYCLES = 8,
    localparam int NG         = (WIDTH + GROUP - 1) / GROUP,
    localparam int LW         = $clog2(NG + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    output logic [WIDTH-1:0] HI,
    output logic             done,
    output logic             busy,
    output logic [LW-1:0]    level
`ifdef MPRJ_LOGIC_LO_EN
    ,
    output logic [WIDTH-1:0] LO
`endif
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LW-1:0] GCNT_MAX  = LW'(NG);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   gcnt_q, gcnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic            done_q, busy_q;
    logic [LW-1:0]   gcnt_inc, gcnt_dec;
    logic [WIDTH-1:0] hi_d;

    assign gcnt_inc = gcnt_q + LW'(1);
    assign gcnt_dec = gcnt_q - LW'(1);

    // Every entry into UP or DOWN takes its first gcnt step on the same edge and restarts scnt.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        scnt_d  = scnt_q;
        case (state_q)
            ST_OFF: begin
                scnt_d = '0;
                if (en) begin
                    gcnt_d  = LW'(1);
                    state_d = (NG == 1) ? ST_ON : ST_UP;
                end
            end
            ST_UP: begin
                if (!en) begin
                    gcnt_d  = gcnt_dec;
                    scnt_d  = '0;
                    state_d = (gcnt_dec == '0) ? ST_OFF : ST_DOWN;
                end else if (scnt_q == SCNT_LAST) begin
                    scnt_d = '0;
                    gcnt_d = gcnt_inc;
                    if (gcnt_inc == GCNT_MAX) begin
                        state_d = ST_ON;
                    end
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_ON: begin
                scnt_d = '0;
                if (!en) begin
                    gcnt_d  = gcnt_dec;
                    state_d = (gcnt_dec == '0) ? ST_OFF : ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (en) begin
                    gcnt_d  = gcnt_inc;
                    scnt_d  = '0;
                    state_d = (gcnt_inc == GCNT_MAX) ? ST_ON : ST_UP;
                end else if (scnt_q == SCNT_LAST) begin
                    scnt_d = '0;
                    gcnt_d = gcnt_dec;
                    if (gcnt_dec == '0) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                gcnt_d  = '0;
                scnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_OFF;
            gcnt_q  <= '0;
            scnt_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            scnt_q  <= scnt_d;
            done_q  <= (state_d == ST_ON);
            busy_q  <= (state_d == ST_UP) || (state_d == ST_DOWN);
        end
    end

    // Line i belongs to group i/GROUP; the top group is naturally truncated at WIDTH-1.
    always_comb begin
        hi_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hi_d[i] = ((i / GROUP) < int'(gcnt_q));
        end
    end

    assign HI    = hi_d;
    assign done  = done_q;
    assign busy  = busy_q;
    assign level = gcnt_q;

`ifdef MPRJ_LOGIC_LO_EN
    assign LO = ~hi_d;
`endif

endmodule
